// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and related shared-resource arbiters.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int GAP_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_DONE = 2'b01,
        GAP       = 2'b10
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter, plus FSM debug state.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    // Requester k holds i_Req[k] and its byte stable until o_Req_Ack[k] pulses; the byte
    // is captured on that same edge, and the requester may drop or replace it next cycle.
    logic [NUM_REQ-1:0]             i_Req;
    logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]             i_Req_Last;
    logic [NUM_REQ-1:0]             o_Req_Ack;
    logic [NUM_REQ-1:0]             o_Req_Done;
    logic [NUM_REQ-1:0]             o_Grant;
    logic                           o_Busy;
    logic                           o_TX_DV;
    logic [UART_BYTE_W-1:0]         o_TX_Byte;
    logic                           i_TX_Active;
    logic                           i_TX_Done;
    arb_state_e                     o_Dbg_State;

    modport master (
        input  i_Req, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
        output o_Req_Ack, o_Req_Done, o_Grant, o_Busy, o_TX_DV, o_TX_Byte, o_Dbg_State
    );

    modport slave (
        output i_Req, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
        input  o_Req_Ack, o_Req_Done, o_Grant, o_Busy, o_TX_DV, o_TX_Byte, o_Dbg_State
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 upward (wrapping) for the first request.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand [N];

    always_comb begin
        cand  = '{default: '0};
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand[i] = IW'((int'(ptr_i) + i + 1) % N);
        end
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[cand[i]]) begin
                any_o           = 1'b1;
                idx_o           = cand[i];
                gnt_o[cand[i]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters.
// Optional packet lock (ownership held until a Last byte) is enabled by UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CLOCKS = 0
) (
    input  logic        i_Clock,
    input  logic        i_Rst_L,
    uart_tx_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        (GAP_CLOCKS > 0) ? GAP_CNT_W'(GAP_CLOCKS - 1) : '0;

    arb_state_e             state_q, state_d;
    logic [GAP_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   dv_q, dv_d;
    logic                   busy_q, busy_d;
    logic [UART_BYTE_W-1:0] byte_q, byte_d;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic                   issue;
    logic [UART_BYTE_W-1:0] win_byte;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;
    // While a packet is open only its owner may issue.
    assign eligible = lock_q ? (bus.i_Req & grant_q) : bus.i_Req;
`else
    logic unused_last;
    assign unused_last = ^bus.i_Req_Last;
    assign eligible    = bus.i_Req;
`endif

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign win_byte = bus.i_Req_Byte[win_idx*UART_BYTE_W +: UART_BYTE_W];
    assign issue    = (state_q == IDLE) && win_any && !bus.i_TX_Active;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            ack_q   <= '0;
            done_q  <= '0;
            grant_q <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            byte_q  <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            byte_q  <= byte_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (issue) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.i_TX_Done) begin
                    if (GAP_CLOCKS > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        dv_d    = 1'b0;
        ack_d   = '0;
        done_d  = '0;
        byte_d  = byte_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        busy_d  = (state_d != IDLE);
`ifdef UART_TX_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        if (issue) begin
            byte_d  = win_byte;
            dv_d    = 1'b1;
            ack_d   = win_oh;
            grant_d = win_oh;
`ifdef UART_TX_ARB_LOCK_EN
            // Rotation only moves on once the packet closes.
            if (bus.i_Req_Last[win_idx]) begin
                ptr_d  = win_idx;
                lock_d = 1'b0;
            end else begin
                lock_d = 1'b1;
            end
`else
            ptr_d = win_idx;
`endif
        end
        if ((state_q == WAIT_DONE) && bus.i_TX_Done) done_d = grant_q;
        if ((state_q != IDLE) && (state_d == IDLE)) begin
`ifdef UART_TX_ARB_LOCK_EN
            if (!lock_q) grant_d = '0;
`else
            grant_d = '0;
`endif
        end
    end

    assign bus.o_Req_Ack   = ack_q;
    assign bus.o_Req_Done  = done_q;
    assign bus.o_Grant     = grant_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_TX_DV     = dv_q;
    assign bus.o_TX_Byte   = byte_q;
    assign bus.o_Dbg_State = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one instance with no gap, one with a 5-clock gap, each with a transmitter model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]   req [2];
    logic [N-1:0]   last [2];
    logic [N-1:0]   hold [2];
    logic [8*N-1:0] rbyte [2];
    logic           mdl_act [2];
    logic           mdl_done [2];
    logic           ext_act [2];

    logic [N-1:0]   ack_s [2];
    logic [N-1:0]   done_s [2];
    logic [N-1:0]   gnt_s [2];
    logic           dv_s [2];
    logic           busy_s [2];
    logic [7:0]     byte_s [2];
    arb_state_e     st_s [2];

    // Per-requester source bytes {last, byte}, expected issues {ack, byte}, expected dones.
    logic [8:0]  src_q [2*N][$];
    logic [11:0] exp_q [2][$];
    logic [3:0]  exp_done_q [2][$];

    uart_tx_arbiter_if #(.NUM_REQ(N)) a_if ();
    uart_tx_arbiter_if #(.NUM_REQ(N)) b_if ();

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLOCKS(0)) u_dut0 (
        .i_Clock (clk),
        .i_Rst_L (rst_n),
        .bus     (a_if.master)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLOCKS(5)) u_dut1 (
        .i_Clock (clk),
        .i_Rst_L (rst_n),
        .bus     (b_if.master)
    );

    assign a_if.i_Req       = req[0];
    assign a_if.i_Req_Byte  = rbyte[0];
    assign a_if.i_Req_Last  = last[0];
    assign a_if.i_TX_Active = mdl_act[0] | ext_act[0];
    assign a_if.i_TX_Done   = mdl_done[0];
    assign ack_s[0]  = a_if.o_Req_Ack;
    assign done_s[0] = a_if.o_Req_Done;
    assign gnt_s[0]  = a_if.o_Grant;
    assign dv_s[0]   = a_if.o_TX_DV;
    assign busy_s[0] = a_if.o_Busy;
    assign byte_s[0] = a_if.o_TX_Byte;
    assign st_s[0]   = a_if.o_Dbg_State;

    assign b_if.i_Req       = req[1];
    assign b_if.i_Req_Byte  = rbyte[1];
    assign b_if.i_Req_Last  = last[1];
    assign b_if.i_TX_Active = mdl_act[1] | ext_act[1];
    assign b_if.i_TX_Done   = mdl_done[1];
    assign ack_s[1]  = b_if.o_Req_Ack;
    assign done_s[1] = b_if.o_Req_Done;
    assign gnt_s[1]  = b_if.o_Grant;
    assign dv_s[1]   = b_if.o_TX_DV;
    assign busy_s[1] = b_if.o_Busy;
    assign byte_s[1] = b_if.o_TX_Byte;
    assign st_s[1]   = b_if.o_Dbg_State;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Queue one byte for requester k of side g and, if it will be issued, its expected results.
    task automatic push(input int g, input int k, input logic [7:0] b, input logic lst,
                        input logic exp_issue, input logic exp_done);
        src_q[g*N+k].push_back({lst, b});
        if (exp_issue) exp_q[g].push_back({4'(1 << k), b});
        if (exp_done)  exp_done_q[g].push_back(4'(1 << k));
    endtask

    task automatic wait_dv(input int g, input int budget, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dv_s[g] && n < budget);
        if (!dv_s[g]) check({name, "_timeout"}, 32'(dv_s[g]), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_side
        initial begin : drv
            req[g]   = '0;
            rbyte[g] = '0;
            last[g]  = '0;
            forever begin
                @(negedge clk);
                for (int k = 0; k < N; k++) begin
                    if (ack_s[g][k] && src_q[g*N+k].size() > 0) void'(src_q[g*N+k].pop_front());
                    req[g][k] = !hold[g][k] && (src_q[g*N+k].size() > 0);
                    if (src_q[g*N+k].size() > 0) begin
                        rbyte[g][8*k +: 8] = src_q[g*N+k][0][7:0];
                        last[g][k]         = src_q[g*N+k][0][8];
                    end
                end
            end
        end

        // Transmitter: Done pulses 6 clocks after the start pulse is seen.
        initial begin : mdl
            mdl_act[g]  = 1'b0;
            mdl_done[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (dv_s[g]) begin
                    mdl_act[g] = 1'b1;
                    repeat (6) @(posedge clk);
                    #1 mdl_done[g] = 1'b1;
                    @(posedge clk);
                    #1 mdl_done[g] = 1'b0;
                    mdl_act[g] = 1'b0;
                end
            end
        end

        initial begin : mon
            logic [11:0] e;
            logic [3:0]  d;
            forever begin
                @(negedge clk);
                if (dv_s[g]) begin
                    if (exp_q[g].size() == 0) check("issue_unexpected", 32'(dv_s[g]), 32'd0);
                    else begin
                        e = exp_q[g].pop_front();
                        check("issue_ack_byte", 32'({ack_s[g], byte_s[g]}), 32'(e));
                    end
                end else if (ack_s[g] != '0) begin
                    check("ack_without_dv", 32'(ack_s[g]), 32'd0);
                end
                if (done_s[g] != '0) begin
                    if (exp_done_q[g].size() == 0) check("done_unexpected", 32'(done_s[g]), 32'd0);
                    else begin
                        d = exp_done_q[g].pop_front();
                        check("req_done", 32'(done_s[g]), 32'(d));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int seen;
        hold[0] = '0;
        hold[1] = '0;
        ext_act[0] = 1'b0;
        ext_act[1] = 1'b0;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_dv",    32'(dv_s[g]),   32'd0);
            check("rst_ack",   32'(ack_s[g]),  32'd0);
            check("rst_done",  32'(done_s[g]), 32'd0);
            check("rst_grant", 32'(gnt_s[g]),  32'd0);
            check("rst_busy",  32'(busy_s[g]), 32'd0);
            check("rst_byte",  32'(byte_s[g]), 32'd0);
            check("rst_state", 32'(st_s[g]),   32'(IDLE));
        end
        rst_n = 1'b1;

        // Single requester 2, byte 5A.
        @(posedge clk); #2;
        push(0, 2, 8'h5A, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("single_dv_latency", 32'(dv_s[0]),  32'd1);
        check("single_grant",      32'(gnt_s[0]), 32'h4);
        check("single_busy",       32'(busy_s[0]), 32'd1);
        repeat (7) @(negedge clk);
        check("single_done_vec",   32'(done_s[0]), 32'h4);
        check("single_busy_fall",  32'(busy_s[0]), 32'd0);
        check("single_grant_idle", 32'(gnt_s[0]),  32'd0);
        repeat (4) @(negedge clk);

        // Fairness: all four requesting; expected order 0,1,2,3,0 at 8-clock spacing.
        do_reset();
        @(posedge clk); #2;
        push(0, 0, 8'h10, 1'b1, 1'b1, 1'b1);
        push(0, 1, 8'h11, 1'b1, 1'b1, 1'b1);
        push(0, 2, 8'h12, 1'b1, 1'b1, 1'b1);
        push(0, 3, 8'h13, 1'b1, 1'b1, 1'b1);
        push(0, 0, 8'h10, 1'b1, 1'b0, 1'b0);
        exp_q[0].push_back({4'b0001, 8'h10});
        exp_done_q[0].push_back(4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_dv(0, 20, "fair_issue", n);
            if (i > 0) check("fair_spacing", 32'(n), 32'd8);
        end
        repeat (12) @(negedge clk);
        check("fair_done_drained", 32'(exp_done_q[0].size()), 32'd0);

        // Gap of 5 clocks on the second instance.
        @(posedge clk); #2;
        push(1, 0, 8'hA0, 1'b1, 1'b1, 1'b1);
        push(1, 1, 8'hA1, 1'b1, 1'b1, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mdl_done[1] && n < 40);
        check("gap_done_seen", 32'(mdl_done[1]), 32'd1);
        wait_dv(1, 20, "gap_issue", n);
        check("gap_spacing", 32'(n), 32'd7);
        repeat (12) @(negedge clk);

`ifdef UART_TX_ARB_LOCK_EN
        // Packet lock: requester 1 sends three bytes with pauses while requester 2 waits.
        do_reset();
        @(posedge clk); #2;
        push(0, 1, 8'hB1, 1'b0, 1'b1, 1'b1);
        push(0, 1, 8'hB2, 1'b0, 1'b1, 1'b1);
        push(0, 1, 8'hB3, 1'b1, 1'b1, 1'b1);
        push(0, 2, 8'hC0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_dv(0, 20, "lock_issue", n);
            hold[0][1] = 1'b1;
            repeat (14) @(negedge clk);
            check("lock_grant_held", 32'(gnt_s[0]),  32'h2);
            check("lock_idle_state", 32'(st_s[0]),   32'(IDLE));
            hold[0][1] = 1'b0;
        end
        wait_dv(0, 20, "lock_last", n);
        wait_dv(0, 20, "lock_next_owner", n);
        check("lock_next_grant", 32'(gnt_s[0]), 32'h4);
        repeat (12) @(negedge clk);
`endif

        // Reset while a byte is in flight; no completion may be reported for it.
        do_reset();
        @(posedge clk); #2;
        push(0, 1, 8'h77, 1'b1, 1'b1, 1'b0);
        wait_dv(0, 20, "rstmid_issue", n);
        repeat (2) @(negedge clk);
        check("rstmid_pre_state", 32'(st_s[0]), 32'(WAIT_DONE));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_dv",    32'(dv_s[0]),   32'd0);
        check("rstmid_grant", 32'(gnt_s[0]),  32'd0);
        check("rstmid_busy",  32'(busy_s[0]), 32'd0);
        check("rstmid_byte",  32'(byte_s[0]), 32'd0);
        check("rstmid_state", 32'(st_s[0]),   32'(IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk); #2;
        push(0, 3, 8'h33, 1'b1, 1'b1, 1'b1);
        wait_dv(0, 20, "rstmid_req3", n);
        check("rstmid_req3_grant", 32'(gnt_s[0]), 32'h8);
        repeat (12) @(negedge clk);

        // Transmitter externally busy: no issue until Active falls, then one clock.
        @(posedge clk); #2;
        ext_act[0] = 1'b1;
        push(0, 0, 8'h44, 1'b1, 1'b1, 1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dv_s[0]) seen++;
        end
        check("busy_no_issue", 32'(seen), 32'd0);
        ext_act[0] = 1'b0;
        wait_dv(0, 10, "busy_issue", n);
        check("busy_latency", 32'(n), 32'd1);
        repeat (12) @(negedge clk);

        for (int g = 0; g < 2; g++) begin
            check("issue_queue_drained", 32'(exp_q[g].size()),      32'd0);
            check("done_queue_drained",  32'(exp_done_q[g].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` byte transmitter among `NUM_REQ` on-chip requesters (command responder, status reporter, debug echo, and so on).
- Accepts one byte at a time from the granted requester and drives the transmitter's `DV`/`Byte` inputs.
- Tracks the transmitter's `Active`/`Done` outputs and returns per-requester accept and completion pulses.
- Sits between the requesters and the single `uart_tx` instance on the serial link.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `GAP_CLOCKS`, default 0: idle clocks inserted after each `i_TX_Done` before the next issue; legal range 0..65535.
- `i_Clock`  in  1: single clock; all logic is on its rising edge.
- `i_Rst_L`  in  1: asynchronous, active-low reset.
- `i_Req`  in  NUM_REQ: bit k high means requester k presents a byte.
- `i_Req_Byte`  in  8*NUM_REQ: flattened bytes; requester k uses bits [8k+7:8k].
- `i_Req_Last`  in  NUM_REQ: the presented byte is the last of a packet. Used only under lock.
- `o_Req_Ack`  out  NUM_REQ: one-hot, 1-cycle pulse; the byte from that requester has been captured.
- `o_Req_Done`  out  NUM_REQ: one-hot, 1-cycle pulse; that requester's byte has finished serialising.
- `o_Grant`  out  NUM_REQ: one-hot current owner; all zero when no owner.
- `o_Busy`  out  1: high in every state except IDLE.
- `o_TX_DV`  out  1: 1-cycle start pulse to `uart_tx`.
- `o_TX_Byte`  out  8: byte to `uart_tx`; held stable until the next issue.
- `i_TX_Active`  in  1: transmitter is serialising.
- `i_TX_Done`  in  1: 1-cycle pulse from the transmitter at the end of the stop bit.

## Operation
- States: IDLE, WAIT_DONE, GAP.
- **IDLE**
  - Arbitrate over the eligible `i_Req` bits.
  - Round-robin search begins at `ptr+1` mod `NUM_REQ`, where `ptr` is the index of the last issued requester. `ptr` resets to `NUM_REQ-1`, so requester 0 wins first.
  - On a winner k:
    - `o_TX_Byte` <= byte k, `o_TX_DV` <= 1, `o_Req_Ack[k]` <= 1.
    - `o_Grant` <= onehot(k), `ptr` <= k.
    - Go to WAIT_DONE.
  - With no eligible request, remain in IDLE with `o_Grant` = 0, unless a lock is held.
  - Issue is also refused while `i_TX_Active` = 1, which protects against an externally busy transmitter.
- **WAIT_DONE**
  - `o_TX_DV` and `o_Req_Ack` return to 0 on the first cycle.
  - On `i_TX_Done`: `o_Req_Done[k]` <= 1. Go to GAP if `GAP_CLOCKS` > 0, otherwise go to IDLE.
  - `i_Req` changes in this state are ignored; the byte is already captured.
- **GAP**
  - Counter loads `GAP_CLOCKS-1` and decrements to 0, then the block goes to IDLE.
  - The gap therefore lasts exactly `GAP_CLOCKS` cycles.
- Requester contract: hold `i_Req[k]` and the byte stable until `o_Req_Ack[k]`. After the ack, drop `i_Req` or present the next byte in the following cycle.
- Simultaneous requests: exactly one grant per issue; rotation guarantees each requester waits at most `NUM_REQ-1` bytes.
- Reset at any time:
  - State returns to IDLE.
  - All outputs go to 0, the counter to 0, and `ptr` to `NUM_REQ-1`.
  - Any byte in flight in `uart_tx` is not tracked; no `o_Req_Done` is produced for it.

## Timing
- Reset values: `o_Req_Ack`=0, `o_Req_Done`=0, `o_Grant`=0, `o_Busy`=0, `o_TX_DV`=0, `o_TX_Byte`=8'h00.
- All outputs are registered; there are no combinational input-to-output paths.
- Request to `o_TX_DV`/`o_Req_Ack`: 1 clock. If `i_Req` is sampled in IDLE at edge N, the pulses are high during cycle N+1.
- `i_TX_Done` to `o_Req_Done`: 1 clock.
- Minimum spacing from `i_TX_Done` to the next `o_TX_DV`:
  - 2 clocks when `GAP_CLOCKS`=0 (back to IDLE, then issue).
  - `GAP_CLOCKS`+2 clocks otherwise.
- `o_Busy` rises together with `o_TX_DV` and falls on the cycle IDLE is re-entered.

## Configuration
- Macro: `UART_TX_ARB_LOCK_EN`.
- Defined (packet lock):
  - After issuing a byte with `i_Req_Last[k]`=0, requester k keeps ownership.
  - In IDLE only requester k is eligible; if it drops `i_Req`, the arbiter waits indefinitely with `o_Grant` held.
  - The lock is released after issuing a byte with `i_Req_Last[k]`=1.
  - `ptr` advances only at release.
  - Reset clears the lock.
- Undefined:
  - `i_Req_Last` is ignored.
  - Re-arbitration happens before every byte and `ptr` advances per byte.
  - `o_Grant` returns to 0 in IDLE.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants: IDLE=2'b00, WAIT_DONE=2'b01, GAP=2'b10.
  - `UART_BYTE_W`=8.
  - Gap counter width 16.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot winner and index.
  - Reused by other shared-resource arbiters.

## Test plan
- **Single requester:** reset, then `i_Req`=4'b0100 with byte 8'h5A.
  - `o_TX_DV` and `o_Req_Ack`=4'b0100 are high one cycle later, with `o_TX_Byte`=8'h5A.
  - A `i_TX_Done` pulse yields `o_Req_Done`=4'b0100 one clock later.
- **Fairness:** all four requesters held high with bytes 8'h10..8'h13 and the lock undefined.
  - Issue order is 0,1,2,3,0, each 8 clocks apart against a transmitter model with 6-clock Done.
- **Gap:** `GAP_CLOCKS`=5 with two pending bytes.
  - Exactly 7 clocks separate the `i_TX_Done` and the second `o_TX_DV`.
- **Lock:** `UART_TX_ARB_LOCK_EN` defined; requester 1 sends 3 bytes with Last on the third while requester 2 is pending.
  - All 3 bytes of requester 1 go first, then requester 2.
  - `o_Grant` stays 4'b0010 through requester 1's pauses.
- **Reset mid-byte:** assert `i_Rst_L`=0 during WAIT_DONE.
  - All outputs go to 0 immediately and state is IDLE.
  - A subsequent `i_Req`=4'b1000 is granted to requester 3, not requester 0.
- **Busy transmitter:** `i_TX_Active`=1 held in IDLE with `i_Req` pending.
  - No `o_TX_DV` while Active is high.
  - Issue occurs 1 clock after Active falls.
